timer_bus_arbiter: RTL and testbench

//  Shares the two Timer/counter devices between two bus masters: M0 (CPU) and M1 (debug/DMA).

---
 rtl/timer_bus_pkg.sv | 27 ++
 rtl/rr_arbiter_2.sv | 14 +
 rtl/timer_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_timer_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_bus_pkg.sv
// Shared encodings and address-window decode for the timer bus arbiter.
package timer_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_TC0  = 2'b01,
    SEL_TC1  = 2'b10
  } sel_t;

  localparam logic [31:0] TC0_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE_DEF = 32'h0000_7F10;
  localparam logic [29:0] WIN_WORDS    = 30'd3;

  // Word offset from the window base; wraps below base, so one compare covers both sides.
  function automatic logic win_hit(input logic [29:0] addr, input logic [31:0] base);
    logic [29:0] off;
    off = addr - base[31:2];
    return off < WIN_WORDS;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: sole requester wins, a tie goes to the master that was not last served.
module rr_arbiter_2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_gnt_vld,
  output logic       o_gnt_id
);

  always_comb begin
    o_gnt_vld = |i_req;
    o_gnt_id  = i_req[1] & (~i_req[0] | ~i_last_grant);
  end

endmodule

// File: rtl/timer_bus_arbiter.sv
// Shares TC0/TC1 between two bus masters with a latch/access/response sequence per transaction.
// Optional BUS_ERR_EN adds m0_err/m1_err flagging accesses that hit neither window.
module timer_bus_arbiter
  import timer_bus_pkg::*;
#(
  parameter logic [31:0] TC0_BASE = TC0_BASE_DEF,
  parameter logic [31:0] TC1_BASE = TC1_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [29:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_req,
  input  logic [29:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
`ifdef BUS_ERR_EN
  output logic        m0_err,
  output logic        m1_err,
`endif
  output logic [29:0] tc0_addr,
  output logic        tc0_we,
  output logic [31:0] tc0_din,
  input  logic [31:0] tc0_dout,
  output logic [29:0] tc1_addr,
  output logic        tc1_we,
  output logic [31:0] tc1_din,
  input  logic [31:0] tc1_dout
);

  state_t      r_state;
  sel_t        r_sel;
  logic        r_last_grant;
  logic        r_win;
  logic [29:0] r_tc0_addr, r_tc1_addr;
  logic        r_tc0_we, r_tc1_we;
  logic [31:0] r_tc0_din, r_tc1_din;
  logic [31:0] r_m0_rdata, r_m1_rdata;
  logic        r_m0_ready, r_m1_ready;
`ifdef BUS_ERR_EN
  logic        r_m0_err, r_m1_err;
`endif

  logic        w_gnt_vld, w_gnt_id;
  logic [29:0] w_addr;
  logic        w_we;
  logic [31:0] w_wdata;
  sel_t        w_sel;
  logic [31:0] w_dout;

  rr_arbiter_2 u_arb (
    .i_req        ({m1_req, m0_req}),
    .i_last_grant (r_last_grant),
    .o_gnt_vld    (w_gnt_vld),
    .o_gnt_id     (w_gnt_id)
  );

  always_comb begin
    w_addr  = w_gnt_id ? m1_addr  : m0_addr;
    w_we    = w_gnt_id ? m1_we    : m0_we;
    w_wdata = w_gnt_id ? m1_wdata : m0_wdata;
    w_sel   = SEL_NONE;
    if (win_hit(w_addr, TC0_BASE))      w_sel = SEL_TC0;
    else if (win_hit(w_addr, TC1_BASE)) w_sel = SEL_TC1;
    w_dout = '0;
    if (r_sel == SEL_TC0)      w_dout = tc0_dout;
    else if (r_sel == SEL_TC1) w_dout = tc1_dout;
  end

  // Device-side registers double as the request latch, so later master changes cannot leak in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sel        <= SEL_NONE;
      r_last_grant <= 1'b1;
      r_win        <= 1'b0;
      r_tc0_addr   <= '0;
      r_tc0_we     <= 1'b0;
      r_tc0_din    <= '0;
      r_tc1_addr   <= '0;
      r_tc1_we     <= 1'b0;
      r_tc1_din    <= '0;
      r_m0_rdata   <= '0;
      r_m0_ready   <= 1'b0;
      r_m1_rdata   <= '0;
      r_m1_ready   <= 1'b0;
`ifdef BUS_ERR_EN
      r_m0_err     <= 1'b0;
      r_m1_err     <= 1'b0;
`endif
    end else begin
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
`ifdef BUS_ERR_EN
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_win      <= w_gnt_id;
            r_sel      <= w_sel;
            r_tc0_addr <= (w_sel == SEL_TC0) ? w_addr  : '0;
            r_tc0_din  <= (w_sel == SEL_TC0) ? w_wdata : '0;
            r_tc0_we   <= (w_sel == SEL_TC0) & w_we;
            r_tc1_addr <= (w_sel == SEL_TC1) ? w_addr  : '0;
            r_tc1_din  <= (w_sel == SEL_TC1) ? w_wdata : '0;
            r_tc1_we   <= (w_sel == SEL_TC1) & w_we;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          r_tc0_addr <= '0;
          r_tc0_din  <= '0;
          r_tc0_we   <= 1'b0;
          r_tc1_addr <= '0;
          r_tc1_din  <= '0;
          r_tc1_we   <= 1'b0;
          r_m0_ready <= ~r_win;
          r_m1_ready <= r_win;
          r_m0_rdata <= r_win ? '0 : w_dout;
          r_m1_rdata <= r_win ? w_dout : '0;
`ifdef BUS_ERR_EN
          r_m0_err   <= ~r_win & (r_sel == SEL_NONE);
          r_m1_err   <= r_win & (r_sel == SEL_NONE);
`endif
          r_state    <= RESP;
        end
        RESP: begin
          r_last_grant <= r_win;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_rdata = r_m0_rdata;
  assign m0_ready = r_m0_ready;
  assign m1_rdata = r_m1_rdata;
  assign m1_ready = r_m1_ready;
`ifdef BUS_ERR_EN
  assign m0_err   = r_m0_err;
  assign m1_err   = r_m1_err;
`endif
  assign tc0_addr = r_tc0_addr;
  assign tc0_we   = r_tc0_we;
  assign tc0_din  = r_tc0_din;
  assign tc1_addr = r_tc1_addr;
  assign tc1_we   = r_tc1_we;
  assign tc1_din  = r_tc1_din;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Scoreboard bench for timer_bus_arbiter: expected responses queued at request time, popped on ready.
module tb_timer_bus_arbiter;

  logic        clk, reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [29:0] m0_addr, m1_addr, tc0_addr, tc1_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready, tc0_we, tc1_we;
  logic [31:0] tc0_din, tc1_din, tc0_dout, tc1_dout;
`ifdef BUS_ERR_EN
  logic        m0_err, m1_err;
`endif

  typedef struct packed {
    logic        m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  timer_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
`ifdef BUS_ERR_EN
    .m0_err(m0_err), .m1_err(m1_err),
`endif
    .tc0_addr(tc0_addr), .tc0_we(tc0_we), .tc0_din(tc0_din), .tc0_dout(tc0_dout),
    .tc1_addr(tc1_addr), .tc1_we(tc1_we), .tc1_din(tc1_din), .tc1_dout(tc1_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model: TC0 words 0x1FC0..0x1FC2, TC1 words 0x1FC4..0x1FC6.
  task automatic issue(input logic m, input logic [29:0] a, input logic w, input logic [31:0] d);
    exp_t e;
    e.m     = m;
    e.err   = 1'b0;
    e.rdata = 32'h0;
    if (a >= 30'h1FC0 && a <= 30'h1FC2)      e.rdata = tc0_dout;
    else if (a >= 30'h1FC4 && a <= 30'h1FC6) e.rdata = tc1_dout;
    else                                      e.err   = 1'b1;
    sb.push_back(e);
    if (!m) begin m0_req = 1'b1; m0_addr = a; m0_we = w; m0_wdata = d; end
    else    begin m1_req = 1'b1; m1_addr = a; m1_we = w; m1_wdata = d; end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    m0_req = 0; m0_addr = '0; m0_we = 0; m0_wdata = '0;
    m1_req = 0; m1_addr = '0; m1_we = 0; m1_wdata = '0;
    tc0_dout = 32'h0; tc1_dout = 32'h0;
    @(negedge clk);
    total++;
    if ({m0_ready, m1_ready, m0_rdata, m1_rdata} !== '0) begin
      bad++; $display("FAIL reset_master got=%b/%b %h/%h want 0", m0_ready, m1_ready, m0_rdata, m1_rdata);
    end
    total++;
    if ({tc0_we, tc1_we, tc0_addr, tc1_addr, tc0_din, tc1_din} !== '0) begin
      bad++; $display("FAIL reset_dev got we=%b/%b addr=%h/%h want 0", tc0_we, tc1_we, tc0_addr, tc1_addr);
    end
`ifdef BUS_ERR_EN
    total++;
    if ({m0_err, m1_err} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b%b want 00", m0_err, m1_err); end
`endif
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({m0_ready, m1_ready, tc0_we, tc1_we} !== 4'b0) begin
        bad++; $display("FAIL idle_quiet cyc=%0d got=%b want 0000", i, {m0_ready, m1_ready, tc0_we, tc1_we});
      end
    end
  endtask

  task automatic test_write;
    exp_t e;
    tc0_dout = 32'h0000_0003;
    issue(1'b0, 30'h1FC0, 1'b1, 32'h0000_0009);
    @(negedge clk);
    total++;
    if (tc0_we !== 1'b1 || tc0_din !== 32'h9 || tc0_addr !== 30'h1FC0) begin
      bad++; $display("FAIL wr_strobe got we=%b din=%h addr=%h want 1/9/1fc0", tc0_we, tc0_din, tc0_addr);
    end
    total++;
    if (tc1_we !== 1'b0 || tc1_addr !== 30'h0 || m0_ready !== 1'b0) begin
      bad++; $display("FAIL wr_other got tc1_we=%b tc1_addr=%h m0_ready=%b want 0", tc1_we, tc1_addr, m0_ready);
    end
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (tc0_we !== 1'b0) begin bad++; $display("FAIL wr_one_cycle got tc0_we=%b want 0", tc0_we); end
    total++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || m0_rdata !== e.rdata) begin
      bad++; $display("FAIL wr_ready got rdy=%b/%b rdata=%h want 1/0 %h", m0_ready, m1_ready, m0_rdata, e.rdata);
    end
`ifdef BUS_ERR_EN
    total++;
    if (m0_err !== e.err) begin bad++; $display("FAIL wr_err got=%b want %b", m0_err, e.err); end
`endif
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if (m0_ready !== 1'b0 || tc1_we !== 1'b0) begin
      bad++; $display("FAIL wr_after got rdy=%b tc1_we=%b want 0", m0_ready, tc1_we);
    end
  endtask

  task automatic test_read;
    exp_t e;
    tc1_dout = 32'h0000_1234;
    issue(1'b1, 30'h1FC6, 1'b0, 32'h0);
    @(negedge clk);
    total++;
    if (tc1_we !== 1'b0 || tc1_addr !== 30'h1FC6 || m1_ready !== 1'b0) begin
      bad++; $display("FAIL rd_access got we=%b addr=%h rdy=%b want 0/1fc6/0", tc1_we, tc1_addr, m1_ready);
    end
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (m1_ready !== 1'b1 || m1_rdata !== e.rdata) begin
      bad++; $display("FAIL rd_ready got rdy=%b rdata=%h want 1 %h", m1_ready, m1_rdata, e.rdata);
    end
    total++;
    if (m0_ready !== 1'b0 || m0_rdata !== 32'h0) begin
      bad++; $display("FAIL rd_loser got rdy=%b rdata=%h want 0 0", m0_ready, m0_rdata);
    end
    m1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alternate;
    exp_t e;
    int c, n, last_c;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tc0_dout = 32'h0000_00A0;
    tc1_dout = 32'h0000_00B1;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 30'h1FC1, 1'b0, 32'h0);
      issue(1'b1, 30'h1FC5, 1'b0, 32'h0);
    end
    n = 0; c = 0; last_c = -1;
    while (n < 6 && c < 40) begin
      @(negedge clk);
      c++;
      if (m0_ready || m1_ready) begin
        e = sb.pop_front();
        total++;
        if (m0_ready !== ~e.m || m1_ready !== e.m || (e.m ? m1_rdata : m0_rdata) !== e.rdata) begin
          bad++; $display("FAIL alt_grant n=%0d got rdy=%b%b rdata=%h/%h want m%0d %h",
                          n, m1_ready, m0_ready, m0_rdata, m1_rdata, e.m, e.rdata);
        end
        if (last_c >= 0) begin
          total++;
          if (c - last_c != 3) begin bad++; $display("FAIL alt_spacing n=%0d got=%0d want 3", n, c - last_c); end
        end
        last_c = c;
        n++;
      end
    end
    total++;
    if (n != 6) begin bad++; $display("FAIL alt_timeout got=%0d readies want 6", n); end
    m0_req = 1'b0;
    m1_req = 1'b0;
    sb.delete();
    @(negedge clk);
  endtask

  task automatic test_none;
    exp_t e;
    logic [29:0] na [2];
    na[0] = 30'h1FC3;
    na[1] = 30'h2000;
    tc0_dout = 32'hDEAD_0000;
    tc1_dout = 32'hBEEF_0000;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, na[i], 1'b1, 32'hFFFF_FFFF);
      @(negedge clk);
      total++;
      if ({tc0_we, tc1_we} !== 2'b00 || tc0_addr !== 30'h0 || tc1_addr !== 30'h0) begin
        bad++; $display("FAIL none_strobe a=%h got we=%b%b addr=%h/%h want 0", na[i], tc0_we, tc1_we, tc0_addr, tc1_addr);
      end
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (m0_ready !== 1'b1 || m0_rdata !== e.rdata) begin
        bad++; $display("FAIL none_ready a=%h got rdy=%b rdata=%h want 1 %h", na[i], m0_ready, m0_rdata, e.rdata);
      end
`ifdef BUS_ERR_EN
      total++;
      if (m0_err !== e.err || m1_err !== 1'b0) begin
        bad++; $display("FAIL none_err a=%h got=%b%b want 0%b", na[i], m1_err, m0_err, e.err);
      end
`endif
      m0_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    tc0_dout = 32'h0000_0042;
    issue(1'b0, 30'h1FC1, 1'b1, 32'h0000_0055);
    @(negedge clk);
    total++;
    if (tc0_we !== 1'b1) begin bad++; $display("FAIL abort_pre got tc0_we=%b want 1", tc0_we); end
    m0_req = 1'b0;
    #1 reset = 1'b1;
    #1;
    total++;
    if (tc0_we !== 1'b0 || tc0_din !== 32'h0) begin
      bad++; $display("FAIL abort_async got we=%b din=%h want 0 0", tc0_we, tc0_din);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL abort_no_ready got=%0d readies want 0", seen); end
    tc1_dout = 32'h0000_0077;
    issue(1'b0, 30'h1FC0, 1'b0, 32'h0);
    issue(1'b1, 30'h1FC4, 1'b0, 32'h0);
    seen = 0;
    for (int i = 0; i < 6 && !(m0_ready || m1_ready); i++) begin
      @(negedge clk);
      seen++;
    end
    total++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || seen != 2 || m0_rdata !== sb[0].rdata) begin
      bad++; $display("FAIL abort_first_grant got rdy=%b%b cyc=%0d rdata=%h want m0 cyc=2 %h",
                      m1_ready, m0_ready, seen, m0_rdata, sb[0].rdata);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_latched;
    exp_t e;
    tc1_dout = 32'h0000_0600;
    issue(1'b1, 30'h1FC5, 1'b1, 32'h1111_2222);
    @(posedge clk);
    #1;
    m1_addr  = 30'h1FC0;
    m1_wdata = 32'h0BAD_0BAD;
    m1_we    = 1'b0;
    @(negedge clk);
    total++;
    if (tc1_we !== 1'b1 || tc1_addr !== 30'h1FC5 || tc1_din !== 32'h1111_2222 || tc0_we !== 1'b0) begin
      bad++; $display("FAIL latch_dev got we=%b addr=%h din=%h tc0_we=%b want 1/1fc5/11112222/0",
                      tc1_we, tc1_addr, tc1_din, tc0_we);
    end
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if (m1_ready !== 1'b1 || m1_rdata !== e.rdata) begin
      bad++; $display("FAIL latch_ready got rdy=%b rdata=%h want 1 %h", m1_ready, m1_rdata, e.rdata);
    end
    m1_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alternate();
    test_none();
    test_reset_mid();
    test_latched();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
